// File: rtl/ecc_ram_zeroize_pkg.sv
// rtl/ecc_ram_zeroize_pkg.sv - shared types and helpers for the ECC RAM zeroize sequencer
package ecc_ram_zeroize_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One sweep cycle clears an even/odd address pair.
  function automatic int unsigned sweep_len(input int unsigned addr_width);
    return 32'd1 << (addr_width - 1);
  endfunction

endpackage

// File: rtl/ecc_ram_zeroize_seq.sv
// rtl/ecc_ram_zeroize_seq.sv - zeroize sweep controller muxed in front of the ECC TDP data RAM
module ecc_ram_zeroize_seq
  import ecc_ram_zeroize_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  zeroize,
  input  logic                  cli_ena,
  input  logic                  cli_wea,
  input  logic [ADDR_WIDTH-1:0] cli_addra,
  input  logic [DATA_WIDTH-1:0] cli_dina,
  input  logic                  cli_enb,
  input  logic                  cli_web,
  input  logic [ADDR_WIDTH-1:0] cli_addrb,
  input  logic [DATA_WIDTH-1:0] cli_dinb,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic [DATA_WIDTH-1:0] ram_dinb,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = ADDR_WIDTH - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(sweep_len(ADDR_WIDTH) - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dina  = '0;
    ram_enb   = 1'b0;
    ram_web   = 1'b0;
    ram_addrb = '0;
    ram_dinb  = '0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        ram_ena   = cli_ena;
        ram_wea   = cli_wea;
        ram_addra = cli_addra;
        ram_dina  = cli_dina;
        ram_enb   = cli_enb;
        ram_web   = cli_web;
        ram_addrb = cli_addrb;
        ram_dinb  = cli_dinb;
      end
      CLEAR: begin
        // Port A takes the even word, port B the odd word of each pair.
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = {cnt_q, 1'b0};
        ram_enb   = 1'b1;
        ram_web   = 1'b1;
        ram_addrb = {cnt_q, 1'b1};
        busy      = 1'b1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A fresh request always (re)starts the sweep from the bottom.
    if (zeroize) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end
  end

endmodule

// File: tb/tb_ecc_ram_zeroize_seq.sv
// tb/tb_ecc_ram_zeroize_seq.sv - directed bench for the ECC RAM zeroize sequencer
module tb_ecc_ram_zeroize_seq;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          zeroize;
  logic          cli_ena, cli_wea, cli_enb, cli_web;
  logic [AW-1:0] cli_addra, cli_addrb;
  logic [DW-1:0] cli_dina, cli_dinb;
  logic          ram_ena, ram_wea, ram_enb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_dinb;
  logic          busy, done;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] douta;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int d0;

  ecc_ram_zeroize_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .zeroize   (zeroize),
    .cli_ena   (cli_ena),
    .cli_wea   (cli_wea),
    .cli_addra (cli_addra),
    .cli_dina  (cli_dina),
    .cli_enb   (cli_enb),
    .cli_web   (cli_web),
    .cli_addrb (cli_addrb),
    .cli_dinb  (cli_dinb),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_enb   (ram_enb),
    .ram_web   (ram_web),
    .ram_addrb (ram_addrb),
    .ram_dinb  (ram_dinb),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first true-dual-port RAM model driven by the DUT's RAM ports.
  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      douta <= mem[ram_addra];
    end
    if (ram_enb && ram_web) mem[ram_addrb] <= ram_dinb;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cli_idle();
    cli_ena = 0; cli_wea = 0; cli_addra = '0; cli_dina = '0;
    cli_enb = 0; cli_web = 0; cli_addrb = '0; cli_dinb = '0;
  endtask

  initial begin
    rst = 1'b1;
    zeroize = 1'b0;
    cli_idle();

    // Reset with arbitrary client inputs: pass-through, not busy
    #1;
    cli_ena = 1; cli_wea = 0; cli_addra = 4'h9; cli_dina = 32'h11223344;
    cli_enb = 1; cli_web = 1; cli_addrb = 4'hA; cli_dinb = 32'h55667788;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addra", 32'(ram_addra), 32'h9);
    check("rst_dina", ram_dina, 32'h11223344);
    check("rst_portb", 32'({ram_enb, ram_web, ram_addrb}), 32'h1A | 32'h20);
    check("rst_dinb", ram_dinb, 32'h55667788);
    cli_idle();
    step();
    step();
    rst = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ena", 32'({ram_ena, ram_enb}), 32'd0);

    // Pass-through write and readback of address 5
    cli_ena = 1; cli_wea = 1; cli_addra = 4'h5; cli_dina = 32'hDEADBEEF;
    #1;
    check("pt_addra", 32'(ram_addra), 32'h5);
    check("pt_dina", ram_dina, 32'hDEADBEEF);
    check("pt_wea", 32'({ram_ena, ram_wea}), 32'h3);
    step();
    cli_wea = 0;
    step();
    cli_idle();
    check("pt_readback5", douta, 32'hDEADBEEF);

    // Preload all 16 words through both client ports
    for (int i = 0; i < 8; i++) begin
      cli_ena = 1; cli_wea = 1; cli_addra = 4'(2 * i);     cli_dina = 32'hA5A5A5A5;
      cli_enb = 1; cli_web = 1; cli_addrb = 4'(2 * i + 1); cli_dinb = 32'hA5A5A5A5;
      step();
    end
    cli_idle();
    check("preload3", mem[3], 32'hA5A5A5A5);
    check("preload14", mem[14], 32'hA5A5A5A5);

    // Full sweep; a blocked client write to addr 3 lands in cycle 2
    d0 = done_cnt;
    zeroize = 1;
    step();
    zeroize = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        cli_enb = 1; cli_web = 1; cli_addrb = 4'h3; cli_dinb = 32'h12345678;
      end
      #1;
      check($sformatf("sw_addra_c%0d", k), 32'(ram_addra), 32'(2 * (k - 1)));
      check($sformatf("sw_addrb_c%0d", k), 32'(ram_addrb), 32'(2 * k - 1));
      check($sformatf("sw_ctl_c%0d", k),
            32'({ram_ena, ram_wea, ram_enb, ram_web, busy, done}), 32'b111110);
      check($sformatf("sw_data_c%0d", k), ram_dina | ram_dinb, 32'd0);
      step();
      cli_idle();
    end
    #1;
    check("done_c9", 32'({busy, done}), 32'b11);
    check("done_c9_ports", 32'({ram_ena, ram_enb, ram_wea, ram_web}), 32'd0);
    check("done_c9_addr", 32'({ram_addra, ram_addrb}), 32'd0);
    step();
    check("idle_c10", 32'({busy, done}), 32'b00);
    check("sweep_done_count", 32'(done_cnt - d0), 32'd1);

    for (int i = 0; i < 16; i++) begin
      cli_ena = 1; cli_wea = 0; cli_addra = 4'(i);
      step();
      check($sformatf("rb_zero_%0d", i), douta, 32'd0);
    end
    cli_idle();
    step();

    // Retrigger while cnt=3
    d0 = done_cnt;
    zeroize = 1;
    step();
    zeroize = 0;
    step();
    step();
    step();
    check("rt_cnt3", 32'(ram_addra), 32'h6);
    zeroize = 1;
    step();
    zeroize = 0;
    check("rt_restart_a", 32'(ram_addra), 32'h0);
    check("rt_restart_b", 32'(ram_addrb), 32'h1);
    check("rt_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 7; k++) step();
    check("rt_last_pair", 32'({ram_addra, done}), 32'({4'hE, 1'b0}));
    step();
    check("rt_done", 32'({busy, done}), 32'b11);
    step();
    check("rt_one_done", 32'(done_cnt - d0), 32'd1);
    check("rt_idle", 32'(busy), 32'd0);

    // Reset mid-sweep at cnt=4
    zeroize = 1;
    step();
    zeroize = 0;
    for (int k = 0; k < 4; k++) step();
    check("mr_cnt4", 32'(ram_addra), 32'h8);
    d0 = done_cnt;
    cli_ena = 1; cli_wea = 0; cli_addra = 4'hC; cli_dina = 32'h0BADF00D;
    rst = 1;
    #1;
    check("mr_busy", 32'({busy, done}), 32'b00);
    check("mr_addra", 32'(ram_addra), 32'hC);
    check("mr_dina", ram_dina, 32'h0BADF00D);
    check("mr_wea", 32'({ram_ena, ram_wea, ram_enb}), 32'b100);
    step();
    step();
    rst = 0;
    for (int k = 0; k < 12; k++) step();
    check("mr_no_done", 32'(done_cnt - d0), 32'd0);
    check("mr_idle", 32'(busy), 32'd0);
    check("mr_mirror", 32'(ram_addra), 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
